// File: rtl/backward_register_slice.sv
// Backward register slice: breaks the ready path from downstream to upstream with a one-entry skid
// buffer. Valid and data pass straight through while the skid register is empty.
module backward_register_slice #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                clki,
  input  logic                rst,
  input  logic                RxVld,
  input  logic [BITWIDTH-1:0] RxData,
  output logic                RxRdy,
  output logic                TxVld,
  output logic [BITWIDTH-1:0] TxData,
  input  logic                TxRdy,
  output logic                SkidVld
);

  logic                r_skid_vld;
  logic [BITWIDTH-1:0] r_skid_data;
  logic                r_rx_rdy;

  logic                w_skid_vld_d;
  logic                w_capture;

  // Capture only when a beat arrives while empty and downstream stalls.
  always_comb begin
    w_capture    = 1'b0;
    w_skid_vld_d = r_skid_vld;
    if (!r_skid_vld) begin
      if (RxVld && !TxRdy) begin
        w_capture    = 1'b1;
        w_skid_vld_d = 1'b1;
      end
    end else if (TxRdy) begin
      w_skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_skid_vld <= 1'b0;
      r_rx_rdy   <= 1'b1;
    end else begin
      r_skid_vld <= w_skid_vld_d;
      r_rx_rdy   <= ~w_skid_vld_d;
    end
  end

  always_ff @(posedge clki) begin
    if (w_capture) begin
      r_skid_data <= RxData;
    end
  end

  assign RxRdy   = r_rx_rdy;
  assign SkidVld = r_skid_vld;
  assign TxVld   = r_skid_vld | RxVld;
  assign TxData  = r_skid_vld ? r_skid_data : RxData;

endmodule

// File: tb/tb_backward_register_slice.sv
// Self-checking bench for backward_register_slice: directed cases plus random traffic checked
// against a queue model of beats held inside the slice.
module tb_backward_register_slice;

  logic       clki;
  logic       rst;
  logic       RxVld;
  logic [7:0] RxData;
  logic       RxRdy;
  logic       TxVld;
  logic [7:0] TxData;
  logic       TxRdy;
  logic       SkidVld;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] m_q[$];
  int unsigned n_acc = 0;
  int unsigned n_del = 0;
  logic        last_acc = 1'b0;
  realtime     last_edge = 0;

  backward_register_slice #(.BITWIDTH(8)) dut (
    .clki   (clki),
    .rst    (rst),
    .RxVld  (RxVld),
    .RxData (RxData),
    .RxRdy  (RxRdy),
    .TxVld  (TxVld),
    .TxData (TxData),
    .TxRdy  (TxRdy),
    .SkidVld(SkidVld)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clki) last_edge = $realtime;

  // Outside reset, ready may only move on a clock edge.
  always @(RxRdy) begin
    if (rst !== 1'b1 && $realtime != 0) chk("rxrdy_sync", ($realtime == last_edge), 1);
  end

  // One clock cycle: drive at negedge, check against model, advance model at posedge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    logic exp_skid, exp_txvld, acc, del, was_empty;
    logic [7:0] exp_data;
    @(negedge clki);
    RxVld  = v;
    RxData = d;
    TxRdy  = r;
    #1;
    exp_skid  = (m_q.size() != 0);
    exp_txvld = exp_skid | v;
    exp_data  = exp_skid ? m_q[0] : d;
    chk("rxrdy", RxRdy, !exp_skid);
    chk("skidvld", SkidVld, exp_skid);
    chk("txvld", TxVld, exp_txvld);
    if (exp_txvld) chk("txdata", TxData, exp_data);
    acc = v && !exp_skid;
    del = exp_txvld && r;
    @(posedge clki);
    if (rst) begin
      m_q.delete();
      last_acc = 1'b0;
    end else begin
      was_empty = (m_q.size() == 0);
      if (acc) n_acc++;
      if (del) n_del++;
      if (del && !was_empty) void'(m_q.pop_front());
      if (acc && !(was_empty && del)) m_q.push_back(d);
      last_acc = acc;
    end
  endtask

  initial begin
    logic       v;
    logic [7:0] d;
    logic       hold;
    int         cyc;

    rst = 1'b1; RxVld = 1'b0; RxData = 8'h00; TxRdy = 1'b0;
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    @(negedge clki);
    rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
    chk("idle_rxrdy", RxRdy, 1);
    chk("idle_txvld", TxVld, 0);

    // Flow-through
    cycle(1'b1, 8'h11, 1'b1);
    chk("flow_11", TxData, 8'h11);
    cycle(1'b1, 8'h22, 1'b1);
    cycle(1'b1, 8'h33, 1'b1);
    chk("flow_skid", SkidVld, 0);

    // Skid capture and hold
    cycle(1'b1, 8'hA5, 1'b0);
    repeat (5) begin
      cycle(1'b1, 8'h5A, 1'b0);
      chk("hold_a5", TxData, 8'hA5);
      chk("hold_rdy", RxRdy, 0);
    end
    cycle(1'b1, 8'h5A, 1'b1);
    chk("drain_a5", TxData, 8'hA5);
    cycle(1'b1, 8'h5A, 1'b1);
    chk("flow_5a", TxData, 8'h5A);
    chk("flow_5a_rdy", RxRdy, 1);

    // Boundary: full, downstream ready, upstream valid
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b1);
    chk("bnd_01", TxData, 8'h01);
    chk("bnd_rdy", RxRdy, 0);
    cycle(1'b1, 8'h02, 1'b1);
    chk("bnd_02", TxData, 8'h02);
    chk("bnd_skid", SkidVld, 0);

    // Reset mid-stall
    cycle(1'b1, 8'hC3, 1'b0);
    @(negedge clki);
    RxVld = 1'b0; TxRdy = 1'b0;
    #1;
    chk("stall_skid", SkidVld, 1);
    chk("stall_c3", TxData, 8'hC3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_skid", SkidVld, 0);
    chk("arst_rdy", RxRdy, 1);
    chk("arst_txvld", TxVld, 0);
    m_q.delete();
    @(negedge clki);
    rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h3C, 1'b1);
    chk("post_rst", TxData, 8'h3C);

    // Random traffic with upstream hold rule
    n_acc = 0; n_del = 0; hold = 1'b0; v = 1'b0; d = 8'h00; cyc = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      if (!hold) begin
        v = 1'($urandom_range(0, 1));
        d = 8'($urandom);
      end
      cycle(v, d, 1'($urandom_range(0, 1)));
      hold = v && !last_acc;
      cyc++;
    end
    chk("rand_budget", (n_acc >= 1000), 1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    chk("rand_count", n_del, n_acc);
    chk("rand_empty", SkidVld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/backward_register_slice.md
Name: backward_register_slice

Overview:
- Companion to the forward register slice. Isolates the ready timing path from slave back to master.
- RxRdy is driven directly from a flop, so the downstream TxRdy never reaches the upstream master combinationally.
- Valid and data stay combinational when the slice is empty: zero latency in the flow-through state, one cycle of latency when the skid register is occupied.
- Sits at block boundaries where TxRdy comes from a long path or a deep combinational cone.

Parameters:
- BITWIDTH, 8, payload width in bits.

Ports:
- clki  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-high.
- RxVld  input  1  upstream valid.
- RxData  input  BITWIDTH  upstream payload.
- RxRdy  output  1  upstream ready, direct flop output.
- TxVld  output  1  downstream valid.
- TxData  output  BITWIDTH  downstream payload.
- TxRdy  input  1  downstream ready.
- SkidVld  output  1  status: skid register holds a beat.

Behaviour:
- Interface: one clock (clki); reset is asynchronous and active-high (rst).
- State:
  - SkidVld flop, resets to 0.
  - SkidData register, BITWIDTH wide, no reset.
  - RxRdy flop, resets to 1.
- Invariant: RxRdy == ~SkidVld at every cycle. Implement as a separate flop, or as the inverted SkidVld flop output; in both cases there is no combinational path from TxRdy to RxRdy.
- Outputs:
  - TxVld = SkidVld | RxVld.
  - TxData = SkidVld ? SkidData : RxData.
- Transfer definitions:
  - Upstream transfer: RxVld & RxRdy.
  - Downstream transfer: TxVld & TxRdy.
- States and transitions:
  - EMPTY (SkidVld=0, RxRdy=1): flow-through.
    - RxVld & ~TxRdy: capture RxData into SkidData, go to FULL (SkidVld=1, RxRdy=0).
    - Otherwise stay EMPTY.
  - FULL (SkidVld=1, RxRdy=0): TxData comes from SkidData, upstream is blocked.
    - TxRdy: go to EMPTY; RxRdy returns to 1 on the next cycle.
    - ~TxRdy: hold, with SkidData stable.
- Boundary cases:
  - FULL & TxRdy & RxVld: the upstream beat is not accepted because RxRdy=0. The master must hold it; it flows through in the next cycle.
  - EMPTY & RxVld & TxRdy: beat passes the same cycle, no capture.
  - EMPTY & ~RxVld: TxVld=0 and TxData = RxData (don't care).
- Ordering: beats are delivered in order with none lost or duplicated. Maximum throughput is 1 beat/cycle while TxRdy stays high.
- Mid-operation reset: asserting rst drops SkidVld immediately (asynchronously). Any beat held in the skid register is discarded; RxRdy goes to 1 and TxVld follows RxVld.
- Reset values:
  - RxRdy=1, SkidVld=0.
  - TxVld=RxVld and TxData=RxData (combinational pass-through).
- Protocol requirements on neighbours: upstream must hold RxVld/RxData stable while RxVld & ~RxRdy. The slice guarantees the same for TxVld/TxData while TxVld & ~TxRdy.
- Do not use TxRdy in any term that drives RxRdy combinationally.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, RxVld=0 -> RxRdy=1, SkidVld=0, TxVld=0. Release rst -> same values.
- Flow-through: TxRdy=1, send 0x11,0x22,0x33 on consecutive cycles -> TxVld=1 in the same cycle as each beat, TxData matches, SkidVld stays 0, RxRdy stays 1.
- Skid capture:
  - Cycle N: RxData=0xA5, RxVld=1, TxRdy=0 -> accepted; cycle N+1: SkidVld=1, RxRdy=0, TxData=0xA5.
  - Upstream presents 0x5A and holds it with TxRdy=0 -> 0xA5 held for 5 cycles.
  - TxRdy=1 -> 0xA5 delivered; next cycle RxRdy=1 and 0x5A flows through.
- Random backpressure: 1000 random bytes, RxVld and TxRdy each random at 50% -> scoreboard matches in order with no loss. RxRdy never changes in the same cycle as a TxRdy edge without a clock edge between them (check via assertion on the registered path).
- Reset mid-stall: SkidVld=1 holding 0xC3, assert rst asynchronously between clock edges -> SkidVld=0 and RxRdy=1 immediately. 0xC3 is never observed after reset.
- Boundary simultaneous: FULL with 0x01, RxVld=1 with 0x02, TxRdy=1 -> 0x01 delivered and 0x02 not accepted that cycle. Next cycle TxRdy=1 -> 0x02 delivered via flow-through.
